seg7_scan_mux: RTL and testbench

Display sequencer that sits downstream of the two-slice 74181 ALU and upstream of the board's 7-segment digit. It selects one of eight nibbles (ALU result, operands, flag byte), decodes it to segments and registers the result. Selection is either static, driven by a config-register field, or automatic, rotating through all nibbles at a programmable dwell. It fills the display-mux slot in the top level and drives the decoded byte into status register 2.

---
 rtl/seg7_scan_mux.sv | 93 +++++++++
 tb/tb_seg7_scan_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Seven-segment display sequencer: picks one of eight ALU-side nibbles, either
// statically from a config field or by auto-rotation at a programmable dwell.
module seg7_scan_mux #(
  parameter int DWELL = 50000,
  parameter int CNT_W = 24
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic       auto,
  input  logic [2:0] sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] f,
  input  logic [7:0] flags,
  output logic [7:0] seg,
  output logic [2:0] nibble_idx,
  output logic       update
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] prescaler;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // NOTE: assign a default before the case so no path leaves nibble unassigned (no latch).
  always_comb begin
    nibble = f[3:0];
    case (nibble_idx)
      3'd0: nibble = f[3:0];
      3'd1: nibble = f[7:4];
      3'd2: nibble = a[3:0];
      3'd3: nibble = a[7:4];
      3'd4: nibble = b[3:0];
      3'd5: nibble = b[7:4];
      3'd6: nibble = flags[3:0];
      3'd7: nibble = flags[7:4];
      default: nibble = f[3:0];
    endcase
    glyph = hex_decode(nibble);
  end

  // Static mode always reloads sel, so leaving auto mode on a terminal-count
  // edge naturally lets the static load win over the increment.
  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      prescaler  <= '0;
      nibble_idx <= 3'd0;
      seg        <= 8'h00;
      update     <= 1'b0;
    end else if (!ena) begin
      update <= 1'b0;
    end else begin
      seg <= {nibble_idx[0], glyph};
      if (!auto) begin
        prescaler  <= '0;
        nibble_idx <= sel;
        update     <= (sel != nibble_idx);
      end else if (prescaler == TERM) begin
        prescaler  <= '0;
        nibble_idx <= nibble_idx + 3'd1;
        update     <= 1'b1;
      end else begin
        prescaler  <= prescaler + CNT_W'(1);
        update     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DWELL=4; expected results are queued
// before each edge and popped for comparison 1 time unit after it.
module tb_seg7_scan_mux;

  logic       clk = 1'b0;
  logic       rstb, ena, auto;
  logic [2:0] sel;
  logic [7:0] a, b, f, flags;
  logic [7:0] seg;
  logic [2:0] nibble_idx;
  logic       update;

  typedef struct {
    logic [7:0] seg;
    logic [2:0] idx;
    logic       upd;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] e_idx = 3'd0;
  logic [7:0] e_seg = 8'h00;

  seg7_scan_mux #(.DWELL(4), .CNT_W(24)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .auto(auto), .sel(sel),
    .a(a), .b(b), .f(f), .flags(flags),
    .seg(seg), .nibble_idx(nibble_idx), .update(update)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  function automatic logic [3:0] nib(input logic [2:0] i);
    logic [31:0] src;
    src = {flags, b, a, f};
    return src[i*4 +: 4];
  endfunction

  // One clock edge: queue what the spec predicts, then compare after the edge.
  task automatic cyc(input logic [2:0] nidx, input logic nupd, input string tag);
    exp_t e, got;
    if (!rstb)     e.seg = 8'h00;
    else if (!ena) e.seg = e_seg;
    else           e.seg = {e_idx[0], hex7(nib(e_idx))};
    e.idx = nidx;
    e.upd = nupd;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e_idx = nidx;
    e_seg = e.seg;
    got = sb.pop_front();
    n_cmp++;
    assert (seg === got.seg) else begin
      n_err++;
      $error("FAIL %s.seg observed=%h expected=%h", got.tag, seg, got.seg);
    end
    n_cmp++;
    assert (nibble_idx === got.idx) else begin
      n_err++;
      $error("FAIL %s.idx observed=%0d expected=%0d", got.tag, nibble_idx, got.idx);
    end
    n_cmp++;
    assert (update === got.upd) else begin
      n_err++;
      $error("FAIL %s.update observed=%b expected=%b", got.tag, update, got.upd);
    end
  endtask

  initial begin
    logic [7:0] sweep [8] = '{8'h39, 8'hCF, 8'h79, 8'hEF, 8'h06, 8'hBF, 8'h3F, 8'hF1};
    rstb = 1'b0; ena = 1'b1; auto = 1'b0; sel = 3'd0;
    a = 8'h00; b = 8'h00; f = 8'h5A; flags = 8'h00;

    // Reset, then release: idx 0 shows f[3:0]=A
    for (int i = 0; i < 3; i++) cyc(3'd0, 1'b0, "reset");
    rstb = 1'b1;
    cyc(3'd0, 1'b0, "release");
    n_cmp++;
    assert (seg === 8'h77) else begin
      n_err++;
      $error("FAIL release_glyph observed=%h expected=77", seg);
    end

    // Static sweep
    f = 8'h3C; a = 8'h9E; b = 8'h01; flags = 8'hF0;
    cyc(3'd0, 1'b0, "sweep0");
    for (int s = 1; s < 8; s++) begin
      sel = 3'(s);
      cyc(3'(s), 1'b1, "sweep_sel");
      cyc(3'(s), 1'b0, "sweep_hold");
      n_cmp++;
      assert (seg === sweep[s]) else begin
        n_err++;
        $error("FAIL sweep_const idx=%0d observed=%h expected=%h", s, seg, sweep[s]);
      end
    end
    sel = 3'd7;
    cyc(3'd7, 1'b0, "same_sel");

    // Source change reaches seg one edge later
    flags = 8'h20;
    cyc(3'd7, 1'b0, "src_change");

    // Auto rotation from idx 0, full wrap after 32 cycles
    sel = 3'd0;
    cyc(3'd0, 1'b1, "to_idx0");
    cyc(3'd0, 1'b0, "idx0_hold");
    auto = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k % 4 == 0) cyc(e_idx + 3'd1, 1'b1, "rot_step");
      else            cyc(e_idx, 1'b0, "rot_wait");
    end
    n_cmp++;
    assert (nibble_idx === 3'd0) else begin
      n_err++;
      $error("FAIL rot_wrap observed=%0d expected=0", nibble_idx);
    end

    // ena gating mid-dwell: step comes exactly 5 cycles late
    cyc(3'd0, 1'b0, "gate_pre");
    cyc(3'd0, 1'b0, "gate_pre");
    ena = 1'b0;
    for (int k = 0; k < 5; k++) cyc(3'd0, 1'b0, "gate_off");
    ena = 1'b1;
    cyc(3'd0, 1'b0, "gate_post");
    cyc(3'd1, 1'b1, "gate_step");

    // Auto exit on terminal-count edge: static load wins
    for (int k = 0; k < 3; k++) cyc(3'd1, 1'b0, "coll_wait");
    auto = 1'b0; sel = 3'd5;
    cyc(3'd5, 1'b1, "collide");
    // Re-entry: rotation starts at 5 with prescaler cleared
    auto = 1'b1;
    for (int k = 0; k < 3; k++) cyc(3'd5, 1'b0, "reenter_wait");
    cyc(3'd6, 1'b1, "reenter_step");

    // Reset mid-rotation at idx 6 (ena low too: reset has priority)
    cyc(3'd6, 1'b0, "pre_rst");
    rstb = 1'b0; ena = 1'b0;
    cyc(3'd0, 1'b0, "mid_reset");
    ena = 1'b1;
    cyc(3'd0, 1'b0, "mid_reset");
    rstb = 1'b1;
    for (int k = 0; k < 3; k++) cyc(3'd0, 1'b0, "resume_wait");
    cyc(3'd1, 1'b1, "resume_step");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
